// File: rtl/cpu_5stage.sv
// cpu_5stage: 32-bit in-order five-stage pipelined core (IF, ID, EX, MEM, WB) with internal imem, dmem, regfile.
// Define FORWARD_EN for EX/MEM->EX, MEM/WB->EX and WB->MEM forwarding; otherwise ID interlocks on producers.
module cpu_5stage #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);

  localparam int DATA_W = 32;
  localparam int IAW    = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DAW    = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_CMP   = 6'b000001;
  localparam logic [5:0] OP_LOAD  = 6'b100011;
  localparam logic [5:0] OP_STORE = 6'b101011;
  localparam logic [5:0] OP_JUMP  = 6'b000010;

  logic [DATA_W-1:0] regfile [0:31]           = '{default: '0};
  logic [DATA_W-1:0] imem    [0:IMEM_WORDS-1] = '{default: '0};
  logic [DATA_W-1:0] dmem    [0:DMEM_WORDS-1] = '{default: '0};

  function automatic logic [IAW-1:0] imem_idx(input logic [DATA_W-1:0] addr);
    return IAW'((addr >> 2) % IMEM_WORDS);
  endfunction

  function automatic logic [DAW-1:0] dmem_idx(input logic [DATA_W-1:0] addr);
    return DAW'((addr >> 2) % DMEM_WORDS);
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  logic [DATA_W-1:0] pc_q, pc_d, if_instr;
  logic [DATA_W-1:0] instr_p0_q, instr_p0_d, pc_p0_q, pc_p0_d;
  logic              vld_p0_q, vld_p0_d;

  logic [5:0]        id_op;
  logic [4:0]        id_rs, id_rt, id_rd, id_dst;
  logic              id_alu, id_cmp, id_load, id_store, id_jump;
  logic              id_use_rs, id_use_rt, id_we, id_stall;
  logic [DATA_W-1:0] id_rs_val, id_rt_val, id_jump_tgt;

  logic              we_p1_q, load_p1_q, store_p1_q, cmp_p1_q;
  logic [4:0]        dst_p1_q;
  logic [DATA_W-1:0] rsv_p1_q, rtv_p1_q, imm_p1_q;
`ifdef FORWARD_EN
  logic [4:0]        rs_p1_q, rt_p1_q, rt_p2_q;
`endif

  logic [DATA_W-1:0]        ex_a, ex_b, ex_res;
  logic signed [DATA_W-1:0] ex_a_s, ex_b_s;

  logic              we_p2_q, load_p2_q, store_p2_q;
  logic [4:0]        dst_p2_q;
  logic [DATA_W-1:0] alu_p2_q, sdata_p2_q, mem_rdata, mem_sdata;
  logic [DAW-1:0]    mem_idx;

  logic              we_p3_q;
  logic [4:0]        dst_p3_q;
  logic [DATA_W-1:0] res_p3_q;

  // IF: combinational fetch, PC advance / hold / redirect
  assign if_instr = imem[imem_idx(pc_q)];

  always_comb begin
    pc_d       = pc_q + 32'd4;
    instr_p0_d = if_instr;
    pc_p0_d    = pc_q;
    vld_p0_d   = 1'b1;
    if (id_stall) begin
      pc_d       = pc_q;
      instr_p0_d = instr_p0_q;
      pc_p0_d    = pc_p0_q;
      vld_p0_d   = vld_p0_q;
    end else if (id_jump) begin
      pc_d     = id_jump_tgt;
      vld_p0_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      vld_p0_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      vld_p0_q <= vld_p0_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_p0_q <= instr_p0_d;
    pc_p0_q    <= pc_p0_d;
  end

  // ID: decode, register read with WB bypass, hazard detection, jump resolution
  assign id_op = instr_p0_q[31:26];
  assign id_rs = instr_p0_q[25:21];
  assign id_rt = instr_p0_q[20:16];
  assign id_rd = instr_p0_q[15:11];

  always_comb begin
    id_alu   = 1'b0;
    id_cmp   = 1'b0;
    id_load  = 1'b0;
    id_store = 1'b0;
    id_jump  = 1'b0;
    if (vld_p0_q) begin
      case (id_op)
        OP_ADD:   id_alu = 1'b1;
        OP_CMP:   begin id_alu = 1'b1; id_cmp = 1'b1; end
        OP_LOAD:  id_load = 1'b1;
        OP_STORE: id_store = 1'b1;
        OP_JUMP:  id_jump = 1'b1;
        default:  ;
      endcase
    end
  end

  assign id_use_rs   = id_alu | id_load | id_store;
  assign id_use_rt   = id_alu | id_store;
  assign id_dst      = id_alu ? id_rd : id_rt;
  assign id_we       = (id_alu | id_load) && (id_dst != 5'd0);
  assign id_jump_tgt = pc_p0_q + {{4{instr_p0_q[25]}}, instr_p0_q[25:0], 2'b00};

  always_comb begin
    id_rs_val = regfile[id_rs];
    id_rt_val = regfile[id_rt];
    if (we_p3_q && dst_p3_q == id_rs) id_rs_val = res_p3_q;
    if (we_p3_q && dst_p3_q == id_rt) id_rt_val = res_p3_q;
    if (id_rs == 5'd0) id_rs_val = '0;
    if (id_rt == 5'd0) id_rt_val = '0;
  end

`ifdef FORWARD_EN
  // Store data is excluded: a loaded value reaches the store in MEM instead.
  assign id_stall = load_p1_q && we_p1_q &&
                    ((id_use_rs && dst_p1_q == id_rs) || (id_alu && dst_p1_q == id_rt));
`else
  logic haz_rs, haz_rt;
  assign haz_rs   = (we_p1_q && dst_p1_q == id_rs) || (we_p2_q && dst_p2_q == id_rs);
  assign haz_rt   = (we_p1_q && dst_p1_q == id_rt) || (we_p2_q && dst_p2_q == id_rt);
  assign id_stall = (id_use_rs && haz_rs) || (id_use_rt && haz_rt);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      we_p1_q    <= 1'b0;
      load_p1_q  <= 1'b0;
      store_p1_q <= 1'b0;
    end else begin
      we_p1_q    <= id_we && !id_stall;
      load_p1_q  <= id_load && !id_stall;
      store_p1_q <= id_store && !id_stall;
    end
  end

  always_ff @(posedge clk) begin
    cmp_p1_q <= id_cmp;
    dst_p1_q <= id_dst;
    rsv_p1_q <= id_rs_val;
    rtv_p1_q <= id_rt_val;
    imm_p1_q <= sext16(instr_p0_q[15:0]);
`ifdef FORWARD_EN
    rs_p1_q  <= id_rs;
    rt_p1_q  <= id_rt;
`endif
  end

  // EX: operand select (younger producer applied last), ALU / compare / address
  always_comb begin
    ex_a = rsv_p1_q;
    ex_b = rtv_p1_q;
`ifdef FORWARD_EN
    if (we_p3_q && dst_p3_q == rs_p1_q) ex_a = res_p3_q;
    if (we_p3_q && dst_p3_q == rt_p1_q) ex_b = res_p3_q;
    if (we_p2_q && !load_p2_q && dst_p2_q == rs_p1_q) ex_a = alu_p2_q;
    if (we_p2_q && !load_p2_q && dst_p2_q == rt_p1_q) ex_b = alu_p2_q;
`endif
  end

  assign ex_a_s = ex_a;
  assign ex_b_s = ex_b;

  always_comb begin
    if (cmp_p1_q)                     ex_res = {31'd0, ex_a_s > ex_b_s};
    else if (load_p1_q | store_p1_q) ex_res = ex_a + imm_p1_q;
    else                              ex_res = ex_a + ex_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_p2_q    <= 1'b0;
      load_p2_q  <= 1'b0;
      store_p2_q <= 1'b0;
    end else begin
      we_p2_q    <= we_p1_q;
      load_p2_q  <= load_p1_q;
      store_p2_q <= store_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    alu_p2_q   <= ex_res;
    sdata_p2_q <= ex_b;
    dst_p2_q   <= dst_p1_q;
`ifdef FORWARD_EN
    rt_p2_q    <= rt_p1_q;
`endif
  end

  // MEM: data memory read, store with WB->MEM data forwarding
  assign mem_idx   = dmem_idx(alu_p2_q);
  assign mem_rdata = dmem[mem_idx];

  always_comb begin
    mem_sdata = sdata_p2_q;
`ifdef FORWARD_EN
    if (we_p3_q && dst_p3_q == rt_p2_q) mem_sdata = res_p3_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (store_p2_q && !reset) dmem[mem_idx] <= mem_sdata;
  end

  always_ff @(posedge clk) begin
    if (reset) we_p3_q <= 1'b0;
    else       we_p3_q <= we_p2_q;
  end

  always_ff @(posedge clk) begin
    res_p3_q <= load_p2_q ? mem_rdata : alu_p2_q;
    dst_p3_q <= dst_p2_q;
  end

  // WB: register 0 never has we_p3_q set
  always_ff @(posedge clk) begin
    if (we_p3_q && !reset) regfile[dst_p3_q] <= res_p3_q;
  end

endmodule

// File: tb/tb_cpu_5stage.sv
// Scoreboard bench for cpu_5stage: directed programs are loaded hierarchically, expected results
// are queued at issue time and a monitor compares them against regfile/dmem when a program completes.
`timescale 1ns/1ps
module tb_cpu_5stage;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  cpu_5stage #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk   (clk),
    .reset (reset)
  );

  typedef struct packed {
    logic        is_mem;
    logic [7:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t  sb_q[$];
  string sb_name_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    drain    = 1'b0;

`ifdef FORWARD_EN
  localparam int LU_EDGES = 7;
`else
  localparam int LU_EDGES = 8;
`endif

  function automatic logic [31:0] i_add(input int rd, input int rs, input int rt);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] i_cmp(input int rd, input int rs, input int rt);
    return {6'b000001, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] i_load(input int rt, input int imm, input int rs);
    return {6'b100011, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] i_store(input int rt, input int imm, input int rs);
    return {6'b101011, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] i_jump(input int off);
    return {6'b000010, 26'(off)};
  endfunction

  task automatic expect_reg(input int r, input logic [31:0] v, input string name);
    exp_t e;
    e.is_mem = 1'b0;
    e.idx    = 8'(r);
    e.val    = v;
    sb_q.push_back(e);
    sb_name_q.push_back(name);
  endtask

  task automatic expect_mem(input int a, input logic [31:0] v, input string name);
    exp_t e;
    e.is_mem = 1'b1;
    e.idx    = 8'(a);
    e.val    = v;
    sb_q.push_back(e);
    sb_name_q.push_back(name);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reset held across one edge so the pipeline is empty, then memories/registers are cleared.
  task automatic hold_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) begin
      dut.imem[i] = '0;
      dut.dmem[i] = '0;
    end
    for (int i = 1; i < 32; i++) dut.regfile[i] = '0;
  endtask

  task automatic run(input int n);
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain_sb();
    drain = 1'b1;
    @(negedge clk);
    #1;
    if (drain) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      drain = 1'b0;
      sb_q.delete();
      sb_name_q.delete();
    end
  endtask

  initial begin : monitor
    exp_t        e;
    string       nm;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (drain) begin
        while (sb_q.size() > 0) begin
          e   = sb_q.pop_front();
          nm  = sb_name_q.pop_front();
          act = e.is_mem ? dut.dmem[e.idx] : dut.regfile[e.idx[4:0]];
          checks++;
          if (act !== e.val) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e.val);
          end
        end
        drain = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "tb_cpu_5stage timeout");
  end

  initial begin : stim
    int edges;

    hold_reset();
    chk("reset_pc", dut.pc_q, 32'd0);
    chk("reset_pipe_empty", {25'd0, dut.vld_p0_q, dut.we_p1_q, dut.load_p1_q, dut.store_p1_q,
                             dut.we_p2_q, dut.store_p2_q, dut.we_p3_q}, 32'd0);

    // Mixed program: ALU, compare, load, store of just-loaded register, jump
    hold_reset();
    dut.regfile[1] = 32'd10;
    dut.regfile[2] = 32'd5;
    dut.regfile[5] = 32'd0;
    dut.dmem[1]    = 32'd100;
    dut.imem[0] = i_add(3, 1, 2);
    dut.imem[1] = i_cmp(4, 1, 2);
    dut.imem[2] = i_load(6, 4, 5);
    dut.imem[3] = i_store(6, 8, 5);
    dut.imem[4] = i_jump(1);
    expect_reg(3, 32'd15, "t1_add_r3");
    expect_reg(4, 32'd1, "t1_cmp_r4");
    expect_reg(6, 32'd100, "t1_load_r6");
    expect_mem(2, 32'd100, "t1_store_dmem2");
    run(20);
    drain_sb();

    // Back-to-back ALU dependency
    hold_reset();
    dut.regfile[1] = 32'd10;
    dut.regfile[2] = 32'd5;
    dut.imem[0] = i_add(3, 1, 2);
    dut.imem[1] = i_add(7, 3, 3);
    expect_reg(3, 32'd15, "t2_add_r3");
    expect_reg(7, 32'd30, "t2_dep_r7");
    run(15);
    drain_sb();

    // Load-use: result value and write-back edge
    hold_reset();
    dut.regfile[1] = 32'd10;
    dut.regfile[5] = 32'd0;
    dut.dmem[1]    = 32'd100;
    dut.imem[0] = i_load(6, 4, 5);
    dut.imem[1] = i_add(8, 6, 1);
    expect_reg(8, 32'd110, "t3_loaduse_r8");
    reset = 1'b0;
    edges = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (dut.regfile[8] == 32'd110) begin
        edges = c;
        break;
      end
    end
    chk("t3_loaduse_wb_edge", edges, LU_EDGES);
    drain_sb();

    // Jump squashes the instruction in IF
    hold_reset();
    dut.regfile[1] = 32'd10;
    dut.regfile[2] = 32'd5;
    dut.imem[0] = i_jump(2);
    dut.imem[1] = i_add(9, 1, 1);
    dut.imem[2] = i_add(10, 1, 2);
    expect_reg(9, 32'd0, "t4_squashed_r9");
    expect_reg(10, 32'd15, "t4_target_r10");
    run(15);
    drain_sb();

    // Compare/add edge cases, unknown opcode, writes to r0
    hold_reset();
    dut.regfile[1]  = 32'd5;
    dut.regfile[2]  = 32'd5;
    dut.regfile[12] = 32'hFFFF_FFFF;
    dut.regfile[13] = 32'd1;
    dut.regfile[11] = 32'hAA;
    dut.regfile[14] = 32'hAA;
    dut.regfile[16] = 32'hAA;
    dut.regfile[17] = 32'h1717;
    dut.regfile[18] = 32'h1818;
    dut.imem[0] = i_cmp(11, 1, 2);
    dut.imem[1] = i_cmp(14, 12, 13);
    dut.imem[2] = i_cmp(15, 13, 12);
    dut.imem[3] = i_add(16, 12, 13);
    dut.imem[4] = {6'b111111, 5'd1, 5'd2, 5'd17, 11'd0};
    dut.imem[5] = i_add(0, 1, 1);
    dut.imem[6] = i_add(18, 0, 0);
    expect_reg(11, 32'd0, "t5_cmp_equal");
    expect_reg(14, 32'd0, "t5_cmp_neg1_gt_1");
    expect_reg(15, 32'd1, "t5_cmp_1_gt_neg1");
    expect_reg(16, 32'd0, "t5_add_wrap");
    expect_reg(17, 32'h1717, "t5_unknown_op_nop");
    expect_reg(18, 32'd0, "t5_read_r0_after_write");
    expect_reg(0, 32'd0, "t5_r0_zero");
    run(20);
    drain_sb();

    // Reset mid-run: committed state kept, in-flight work discarded
    hold_reset();
    dut.regfile[1] = 32'd10;
    dut.regfile[2] = 32'd5;
    dut.imem[0] = i_add(3, 1, 2);
    dut.imem[3] = i_store(1, 12, 0);
    dut.imem[4] = i_add(21, 1, 1);
    run(5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_reset_pc", dut.pc_q, 32'd0);
    chk("t6_reset_pipe_empty", {25'd0, dut.vld_p0_q, dut.we_p1_q, dut.load_p1_q, dut.store_p1_q,
                                dut.we_p2_q, dut.store_p2_q, dut.we_p3_q}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    expect_reg(3, 32'd15, "t6_committed_r3");
    expect_mem(3, 32'd0, "t6_inflight_store_dropped");
    expect_reg(21, 32'd0, "t6_inflight_add_dropped");
    expect_reg(0, 32'd0, "t6_r0_zero");
    drain_sb();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
